duck_flock: RTL and testbench

Multi-target successor to the single-duck motion controller. It animates `N_DUCKS` independent ducks per round, each running its own fly/hit/fall/escape state machine on frame ticks. It resolves which duck, if any, owns the current VGA pixel and produces that duck's sprite-sheet address. It sits between the round-level game FSM, which supplies round start and shot hits, and the colour mapper, which consumes `is_duck` and `duck_addr`.

---
 rtl/duck_flock.sv | 222 ++++++++++++++++++++++
 tb/tb_duck_flock.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/duck_flock.sv
// duck_flock: N_DUCKS independent duck motion FSMs driven by synchronised frame ticks,
// plus the pixel-ownership / sprite-address path. Define DUCK_FLOCK_RANDOM_EN for LFSR-varied steps.
module duck_flock #(
  parameter int N_DUCKS       = 2,
  parameter int SIZE          = 64,
  parameter int SHEET_W       = 320,
  parameter int ADDR_W        = 16,
  parameter int X_MIN         = 40,
  parameter int X_MAX         = 576,
  parameter int Y_MIN         = 40,
  parameter int Y_MAX         = 245,
  parameter int STEP          = 2,
  parameter int FALL_STEP     = 3,
  parameter int HIT_FRAMES    = 15,
  parameter int ESCAPE_FRAMES = 450,
  parameter int FLAP_FRAMES   = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic                  round_start,
  input  logic                  shot_valid,
  input  logic [1:0]            shot_idx,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  output logic                  is_duck,
  output logic [ADDR_W-1:0]     duck_addr,
  output logic [10*N_DUCKS-1:0] duck_x,
  output logic [10*N_DUCKS-1:0] duck_y,
  output logic [N_DUCKS-1:0]    flew_away,
  output logic [N_DUCKS-1:0]    dead_done,
  output logic                  round_done
);

  localparam int FC_W   = $clog2(ESCAPE_FRAMES + 1);
  localparam int HIT_W  = $clog2(HIT_FRAMES + 1);
  localparam int FLAP_W = $clog2(FLAP_FRAMES + 1);
  localparam logic signed [10:0] SIZE_S  = 11'(SIZE);
  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

  typedef enum logic [2:0] {S_IDLE, S_FLY, S_HIT, S_FALL, S_DONE, S_ESC} state_t;

  state_t              state_q [N_DUCKS], state_d [N_DUCKS];
  logic [9:0]          x_q [N_DUCKS], x_d [N_DUCKS], y_q [N_DUCKS], y_d [N_DUCKS];
  logic [2:0]          step_q [N_DUCKS], step_d [N_DUCKS];
  logic [2:0]          frame_q [N_DUCKS], frame_d [N_DUCKS];
  logic [FC_W-1:0]     fly_cnt_q [N_DUCKS], fly_cnt_d [N_DUCKS];
  logic [HIT_W-1:0]    hit_cnt_q [N_DUCKS], hit_cnt_d [N_DUCKS];
  logic [FLAP_W-1:0]   flap_cnt_q [N_DUCKS], flap_cnt_d [N_DUCKS];
  logic [3:0]          fall_cnt_q [N_DUCKS], fall_cnt_d [N_DUCKS];
  logic [N_DUCKS-1:0]  dxn_q, dxn_d, dyn_q, dyn_d, facing_q, facing_d, rel_q, rel_d;
  logic [N_DUCKS-1:0]  flew_q, flew_d, dead_q, dead_d;
  logic [2:0]          fs_q;
  logic                tick_s;
  logic [2:0]          launch_step_s;
  logic                launch_dxn_s;
  logic signed [10:0]  step_s, nx_s, ny_s, ddx_s, ddy_s;
  logic [10:0]         fy_s;
  logic                rel_n_s, found_s, all_done_s;

  // Bounce/launch step source: LFSR-varied or fixed
`ifdef DUCK_FLOCK_RANDOM_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  assign launch_step_s = 3'd1 + {1'b0, lfsr_q[1:0]};
  assign launch_dxn_s  = lfsr_q[2];
`else
  assign launch_step_s = 3'(STEP);
  assign launch_dxn_s  = 1'b1;
`endif

  // Frame clock synchroniser and rising-edge tick
  always_ff @(posedge Clk) begin
    if (Reset) fs_q <= 3'b000;
    else       fs_q <= {fs_q[1:0], frame_clk};
  end
  assign tick_s = fs_q[1] & ~fs_q[2];

  // State register for every duck channel
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_DUCKS; i++) begin
        state_q[i]    <= S_IDLE;
        x_q[i]        <= 10'(X_MAX - i * SIZE);
        y_q[i]        <= 10'(Y_MAX);
        step_q[i]     <= 3'(STEP);
        frame_q[i]    <= 3'd0;
        fly_cnt_q[i]  <= '0;
        hit_cnt_q[i]  <= '0;
        flap_cnt_q[i] <= '0;
        fall_cnt_q[i] <= 4'd0;
      end
      dxn_q <= '1; dyn_q <= '1; facing_q <= '0; rel_q <= '0;
      flew_q <= '0; dead_q <= '0;
    end else begin
      state_q <= state_d; x_q <= x_d; y_q <= y_d; step_q <= step_d; frame_q <= frame_d;
      fly_cnt_q <= fly_cnt_d; hit_cnt_q <= hit_cnt_d; flap_cnt_q <= flap_cnt_d; fall_cnt_q <= fall_cnt_d;
      dxn_q <= dxn_d; dyn_q <= dyn_d; facing_q <= facing_d; rel_q <= rel_d;
      flew_q <= flew_d; dead_q <= dead_d;
    end
  end

  // Next-state and motion update per duck
  always_comb begin
    step_s = '0; nx_s = '0; ny_s = '0; fy_s = '0; rel_n_s = 1'b0;
    flew_d = '0; dead_d = '0;
    dxn_d = dxn_q; dyn_d = dyn_q; facing_d = facing_q; rel_d = rel_q;
    for (int i = 0; i < N_DUCKS; i++) begin
      state_d[i] = state_q[i]; x_d[i] = x_q[i]; y_d[i] = y_q[i]; step_d[i] = step_q[i];
      frame_d[i] = frame_q[i]; fly_cnt_d[i] = fly_cnt_q[i]; hit_cnt_d[i] = hit_cnt_q[i];
      flap_cnt_d[i] = flap_cnt_q[i]; fall_cnt_d[i] = fall_cnt_q[i];
      step_s = $signed({8'd0, step_q[i]});
      nx_s = dxn_q[i] ? $signed({1'b0, x_q[i]}) - step_s : $signed({1'b0, x_q[i]}) + step_s;
      ny_s = dyn_q[i] ? $signed({1'b0, y_q[i]}) - step_s : $signed({1'b0, y_q[i]}) + step_s;
      fy_s = {1'b0, y_q[i]} + 11'(FALL_STEP);
      if (round_start) begin
        state_d[i] = S_FLY; x_d[i] = 10'(X_MAX - i * SIZE); y_d[i] = 10'(Y_MAX);
        step_d[i] = launch_step_s; dxn_d[i] = launch_dxn_s; dyn_d[i] = 1'b1;
        facing_d[i] = ~launch_dxn_s; rel_d[i] = 1'b0; frame_d[i] = 3'd0;
        fly_cnt_d[i] = '0; flap_cnt_d[i] = '0; hit_cnt_d[i] = '0; fall_cnt_d[i] = 4'd0;
      end else begin
        case (state_q[i])
          S_FLY: begin
            // A hit in the same cycle as a tick or an escape takes priority
            if (shot_valid && (int'(shot_idx) == i)) begin
              state_d[i] = S_HIT; frame_d[i] = 3'd3; hit_cnt_d[i] = '0;
            end else if (tick_s) begin
              x_d[i] = nx_s[9:0]; y_d[i] = ny_s[9:0];
              if (nx_s >= X_MAX_S) begin
                dxn_d[i] = 1'b1; facing_d[i] = 1'b0; step_d[i] = launch_step_s;
              end else if (nx_s <= X_MIN_S) begin
                dxn_d[i] = 1'b0; facing_d[i] = 1'b1; step_d[i] = launch_step_s;
              end else begin
                dxn_d[i] = dxn_q[i];
              end
              if (flap_cnt_q[i] == FLAP_W'(FLAP_FRAMES - 1)) begin
                flap_cnt_d[i] = '0;
                frame_d[i] = (frame_q[i] == 3'd2) ? 3'd0 : frame_q[i] + 3'd1;
              end else begin
                flap_cnt_d[i] = flap_cnt_q[i] + FLAP_W'(1);
              end
              if (fly_cnt_q[i] < FC_W'(ESCAPE_FRAMES)) fly_cnt_d[i] = fly_cnt_q[i] + FC_W'(1);
              else fly_cnt_d[i] = fly_cnt_q[i];
              rel_n_s = rel_q[i] | (fly_cnt_d[i] >= FC_W'(ESCAPE_FRAMES));
              rel_d[i] = rel_n_s;
              if (ny_s >= Y_MAX_S) dyn_d[i] = 1'b1;
              else if ((ny_s <= Y_MIN_S) && !rel_n_s) dyn_d[i] = 1'b0;
              else dyn_d[i] = dyn_q[i];
              if (rel_n_s && (ny_s <= step_s)) begin
                state_d[i] = S_ESC; flew_d[i] = 1'b1;
              end else begin
                state_d[i] = S_FLY;
              end
            end else begin
              state_d[i] = S_FLY;
            end
          end
          S_HIT: begin
            if (tick_s && (hit_cnt_q[i] == HIT_W'(HIT_FRAMES - 1))) begin
              state_d[i] = S_FALL; frame_d[i] = 3'd4; fall_cnt_d[i] = 4'd0;
            end else if (tick_s) begin
              hit_cnt_d[i] = hit_cnt_q[i] + HIT_W'(1);
            end else begin
              state_d[i] = S_HIT;
            end
          end
          S_FALL: begin
            if (tick_s) begin
              if (fall_cnt_q[i] == 4'd9) begin
                fall_cnt_d[i] = 4'd0; facing_d[i] = ~facing_q[i];
              end else begin
                fall_cnt_d[i] = fall_cnt_q[i] + 4'd1;
              end
              if (fy_s >= 11'(Y_MAX)) begin
                y_d[i] = 10'(Y_MAX); state_d[i] = S_DONE; dead_d[i] = 1'b1;
              end else begin
                y_d[i] = fy_s[9:0];
              end
            end else begin
              state_d[i] = S_FALL;
            end
          end
          default: state_d[i] = state_q[i];
        endcase
      end
    end
  end

  // Pixel ownership, sprite address and status outputs
  always_comb begin
    is_duck = 1'b0; duck_addr = '0; found_s = 1'b0; all_done_s = 1'b1;
    ddx_s = '0; ddy_s = '0; duck_x = '0; duck_y = '0;
    for (int i = 0; i < N_DUCKS; i++) begin
      duck_x[i*10 +: 10] = x_q[i];
      duck_y[i*10 +: 10] = y_q[i];
      ddx_s = $signed({1'b0, DrawX}) - $signed({1'b0, x_q[i]});
      ddy_s = $signed({1'b0, DrawY}) - $signed({1'b0, y_q[i]});
      if (!found_s && ((state_q[i] == S_FLY) || (state_q[i] == S_HIT) || (state_q[i] == S_FALL)) &&
          (ddx_s >= 11'sd0) && (ddx_s < SIZE_S) && (ddy_s >= 11'sd0) && (ddy_s < SIZE_S)) begin
        found_s = 1'b1;
        is_duck = 1'b1;
        duck_addr = ADDR_W'((32'(ddy_s[9:0]) + 32'(facing_q[i]) * 32'(SIZE)) * 32'(SHEET_W)
                            + 32'(ddx_s[9:0]) + 32'(frame_q[i]) * 32'(SIZE));
      end else begin
        found_s = found_s;
      end
      if ((state_q[i] != S_DONE) && (state_q[i] != S_ESC)) all_done_s = 1'b0;
      else all_done_s = all_done_s;
    end
    round_done = all_done_s;
  end

  assign flew_away = flew_q;
  assign dead_done = dead_q;

endmodule

// File: tb/tb_duck_flock.sv
// Directed self-checking bench for duck_flock (default build, N_DUCKS = 2).
module tb_duck_flock;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        round_start = 1'b0;
  logic        shot_valid = 1'b0;
  logic [1:0]  shot_idx = 2'd0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic        is_duck;
  logic [15:0] duck_addr;
  logic [19:0] duck_x, duck_y;
  logic [1:0]  flew_away, dead_done;
  logic        round_done;

  int n_checks = 0;
  int n_fail = 0;
  int fa0 = 0, fa1 = 0, dd0 = 0, dd1 = 0;

  duck_flock dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .round_start(round_start),
    .shot_valid(shot_valid), .shot_idx(shot_idx), .DrawX(DrawX), .DrawY(DrawY),
    .is_duck(is_duck), .duck_addr(duck_addr), .duck_x(duck_x), .duck_y(duck_y),
    .flew_away(flew_away), .dead_done(dead_done), .round_done(round_done)
  );

  always #10 Clk = ~Clk;

  // Pulse counters sampled on the inactive edge
  always @(negedge Clk) begin
    if (flew_away[0]) fa0++;
    if (flew_away[1]) fa1++;
    if (dead_done[0]) dd0++;
    if (dead_done[1]) dd1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input int px, input int py, input logic vis, input int addr);
    DrawX = 10'(px);
    DrawY = 10'(py);
    #1;
    check({tag, ".is_duck"}, 32'(is_duck), 32'(vis));
    check({tag, ".addr"}, 32'(duck_addr), 32'(addr));
  endtask

  task automatic do_tick();
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 round_start = 1'b1;
    @(posedge Clk); #1 round_start = 1'b0;
  endtask

  task automatic pulse_shot(input logic [1:0] idx);
    @(posedge Clk); #1 shot_valid = 1'b1; shot_idx = idx;
    @(posedge Clk); #1 shot_valid = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int x0, input int y0, input int x1, input int y1);
    check({tag, ".x0"}, 32'(duck_x[9:0]), 32'(x0));
    check({tag, ".y0"}, 32'(duck_y[9:0]), 32'(y0));
    check({tag, ".x1"}, 32'(duck_x[19:10]), 32'(x1));
    check({tag, ".y1"}, 32'(duck_y[19:10]), 32'(y1));
  endtask

  initial begin
    int esc0, esc1, yexp;
    bit finished;
    esc0 = 0; esc1 = 0; finished = 1'b0;

    // Reset state
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check_pos("reset", 576, 245, 512, 245);
    check("reset.round_done", 32'(round_done), 32'd0);
    check("reset.flew", 32'(flew_away), 32'd0);
    check("reset.dead", 32'(dead_done), 32'd0);
    probe("reset.idle_pix", 580, 250, 1'b0, 0);

    // Launch
    pulse_start();
    check_pos("launch", 576, 245, 512, 245);
    probe("launch.d0", 580, 250, 1'b1, 1604);
    check("launch.round_done", 32'(round_done), 32'd0);

    for (int n = 1; n <= 21; n++) begin
      do_tick();
      check("fly.x0", 32'(duck_x[9:0]), 32'(576 - 2 * n));
      if (n == 1) check_pos("tick1", 574, 243, 510, 243);
    end
    check_pos("tick21", 534, 203, 470, 203);
    probe("tick21.frame1", 473, 210, 1'b1, 2307);

    // Out-of-range shot index is ignored
    pulse_shot(2'd2);
    pulse_shot(2'd3);
    probe("badidx", 473, 210, 1'b1, 2307);

    // Hit duck1: frame 3 for 15 ticks, no motion
    pulse_shot(2'd1);
    probe("hit.frame3", 473, 210, 1'b1, 2435);
    for (int k = 1; k <= 15; k++) begin
      do_tick();
      if (k < 15) begin
        check("hit.y1", 32'(duck_y[19:10]), 32'd203);
        check("hit.x1", 32'(duck_x[19:10]), 32'd470);
        probe("hit.hold", 473, 210, 1'b1, 2435);
      end
      if (k == 7) pulse_shot(2'd1);
    end
    probe("fall.frame4", 473, 210, 1'b1, 2499);

    // Fall 3 per tick, clamp at ground
    for (int k = 1; k <= 14; k++) begin
      do_tick();
      yexp = 203 + 3 * k;
      if (yexp > 245) yexp = 245;
      check("fall.y1", 32'(duck_y[19:10]), 32'(yexp));
      if (k == 1) begin
        probe("overlap.d0wins", 510, 210, 1'b1, 12552);
        probe("fall.k1", 473, 213, 1'b1, 2499);
      end
      if (k == 9)  probe("fall.facing_l", 473, 237, 1'b1, 2499);
      if (k == 10) probe("fall.facing_r", 473, 240, 1'b1, 22979);
    end
    repeat (2) @(posedge Clk);
    #1;
    check("dead1.count", 32'(dd1), 32'd1);
    check("dead0.count", 32'(dd0), 32'd0);
    probe("done.invisible", 473, 252, 1'b0, 0);
    check_pos("tick50", 476, 145, 470, 245);
    check("tick50.round_done", 32'(round_done), 32'd0);

    // Shot coincident with tick: hit wins, no motion
    @(posedge Clk); #1 frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1 shot_valid = 1'b1; shot_idx = 2'd0;
    @(posedge Clk); #1 shot_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("coinc.x0", 32'(duck_x[9:0]), 32'd476);
    check("coinc.y0", 32'(duck_y[9:0]), 32'd145);
    probe("coinc.frame3", 477, 146, 1'b1, 513);
    repeat (17) do_tick();
    check("fall0.y0", 32'(duck_y[9:0]), 32'd151);
    probe("fall0.frame4", 477, 152, 1'b1, 577);

    // Relaunch mid-FALL
    pulse_start();
    check_pos("relaunch", 576, 245, 512, 245);
    probe("relaunch.d0", 580, 250, 1'b1, 1604);
    probe("relaunch.d1", 515, 250, 1'b1, 1603);
    check("relaunch.round_done", 32'(round_done), 32'd0);

    // No shots: bounces, release at 450, escape
    for (int n = 1; n <= 800 && !finished; n++) begin
      do_tick();
      if (n == 102) check("ymin.pre", 32'(duck_y[19:10]), 32'd41);
      if (n == 103) check("ymin.at", 32'(duck_y[19:10]), 32'd39);
      if (n == 104) check("ymin.bounce", 32'(duck_y[19:10]), 32'd41);
      if (n == 250) begin
        check_pos("tick250", 76, 157, 68, 157);
        probe("d1.right_frame2", 70, 160, 1'b1, 21570);
        probe("overlap2.d0wins", 78, 162, 1'b1, 1730);
      end
      if (fa0 != 0 && esc0 == 0) esc0 = n;
      if (fa1 != 0 && esc1 == 0) esc1 = n;
      if (round_done) finished = 1'b1;
    end
    check("escape.round_done_reached", 32'(finished), 32'd1);
    check("escape.tick0", 32'(esc0), 32'd534);
    check("escape.tick1", 32'(esc1), 32'd534);
    probe("escape.invisible", 580, 10, 1'b0, 0);
    repeat (3) do_tick();
    check("escape.fa0", 32'(fa0), 32'd1);
    check("escape.fa1", 32'(fa1), 32'd1);
    check("escape.round_done_held", 32'(round_done), 32'd1);

    // Reset mid-round
    pulse_start();
    repeat (3) do_tick();
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    check_pos("midreset", 576, 245, 512, 245);
    check("midreset.round_done", 32'(round_done), 32'd0);
    probe("midreset.idle", 580, 250, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
